// File: rtl/parity_check.sv
// Receive-side parity checker: registers each valid word through with one cycle
// of latency, flags per-byte parity mismatches and keeps error statistics.
module parity_check #(
  parameter int ODD        = 0,
  parameter int CNT_W      = 16,
  parameter int IRQ_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      din,
  input  logic [3:0]       parity_in,
  input  logic             din_valid,
  input  logic             clr,
  output logic [31:0]      dout,
  output logic             dout_valid,
  output logic [3:0]       byte_err,
  output logic             word_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_data,
  output logic [3:0]       first_err_byte,
  output logic             err_irq
);

  localparam bit               ODD_BIT   = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] IRQ_LEVEL = CNT_W'(IRQ_THRESH);

  logic [3:0]       mism;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic             sticky_base, sticky_next;
  logic [31:0]      fd_base, fd_next;
  logic [3:0]       fb_base, fb_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 4; i++) begin
      mism[i] = din_valid & ((^din[8*i +: 8] ^ ODD_BIT) != parity_in[i]);
    end
  end

  // A clear acts before this cycle's word, so a colliding error is the new first error.
  always_comb begin
    cnt_base    = clr ? '0    : err_count;
    sticky_base = clr ? 1'b0  : err_sticky;
    fd_base     = clr ? '0    : first_err_data;
    fb_base     = clr ? '0    : first_err_byte;
    cnt_next    = cnt_base;
    sticky_next = sticky_base;
    fd_next     = fd_base;
    fb_next     = fb_base;
    if (|mism) begin
      sticky_next = 1'b1;
      if (!sticky_base) begin
        fd_next = din;
        fb_next = mism;
      end
      if (cnt_base != CNT_MAX) begin
        cnt_next = cnt_base + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: dout is a plain register, not a memory, so it is reset along with everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout           <= '0;
      dout_valid     <= 1'b0;
      byte_err       <= '0;
      err_count      <= '0;
      err_sticky     <= 1'b0;
      first_err_data <= '0;
      first_err_byte <= '0;
    end else begin
      if (din_valid) begin
        dout       <= din;
        dout_valid <= 1'b1;
        byte_err   <= mism;
      end else begin
        dout_valid <= 1'b0;
        byte_err   <= '0;
      end
      err_count      <= cnt_next;
      err_sticky     <= sticky_next;
      first_err_data <= fd_next;
      first_err_byte <= fb_next;
    end
  end

  assign word_err = |byte_err;
  assign err_irq  = err_sticky && (err_count >= IRQ_LEVEL);

endmodule

// File: doc/parity_check.md
# parity_check

Receive-side companion of the `parity` generator. It takes a 32-bit data word plus 4 per-byte parity bits from the link and recomputes parity for each byte. It flags mismatches per byte and per word, and keeps error statistics: a saturating counter, a sticky flag, first-error capture and a threshold interrupt. It sits at the sink of any path protected by `parity`, registering data through with one cycle of latency.

## Interface
Parameters:
- `ODD`, default 0: 0 = even parity, so `parity[i] = ^din[8i+7:8i]`; 1 = odd parity, the inverted value.
- `CNT_W`, default 16: width of the error counter.
- `IRQ_THRESH`, default 1: `err_irq` asserts when `err_count >= IRQ_THRESH`. The legal range is 1 to 2^CNT_W-1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `din`  in  32  received data word.
- `parity_in`  in  4  received parity; bit i covers `din[8i+7:8i]`.
- `din_valid`  in  1  qualifies `din` and `parity_in` in this cycle.
- `clr`  in  1  one-cycle pulse; clears the statistics.
- `dout`  out  32  registered copy of the last valid `din`.
- `dout_valid`  out  1  `dout` was loaded on the last edge.
- `byte_err`  out  4  per-byte mismatch for the word on `dout`.
- `word_err`  out  1  equals `|byte_err`.
- `err_sticky`  out  1  set when any error is seen since reset or `clr`.
- `err_count`  out  CNT_W  number of erroneous words, saturating.
- `first_err_data`  out  32  data of the first erroneous word since reset or `clr`.
- `first_err_byte`  out  4  `byte_err` pattern of that first erroneous word.
- `err_irq`  out  1  equals `err_sticky && (err_count >= IRQ_THRESH)`.

## Operation
- Check stage: `exp[i] = ^din[8i+7:8i] ^ ODD`; `mism[i] = din_valid & (exp[i] != parity_in[i])`.
- Edge with `din_valid=1`: `dout <= din`, `dout_valid <= 1`, `byte_err <= mism`.
- Edge with `din_valid=0`: `dout` holds, `dout_valid <= 0`, `byte_err <= 0`.
- Counter: increments by exactly 1 per erroneous word, regardless of how many bytes are bad. It holds at 2^CNT_W-1 and does not wrap.
- Error capture, on a valid word with `mism != 0`:
  - `err_sticky <= 1`.
  - If `err_sticky` was 0 (after any clr applied this cycle), load `first_err_data` and `first_err_byte`.
  - Later errors do not overwrite the capture.
- `clr` affects only `err_count`, `err_sticky`, `first_err_*` and therefore `err_irq`. The data path is unaffected.
- `clr` in the same cycle as an erroneous valid word: the clear applies first, then the word is counted. Result: `err_count=1`, `err_sticky=1`, first-error capture = this word.
- `err_irq` is combinational from registered state and needs no extra flop.

## Timing
- Reset: while `rst_n=0` at an edge, every output register goes to 0. That means `dout=0`, `dout_valid=0`, `byte_err=0`, `err_count=0`, `err_sticky=0`, `first_err_*=0`, and hence `err_irq=0`. Inputs are ignored during that cycle.
- Reset mid-stream: a word presented in the reset cycle is dropped and not counted. The first valid word after `rst_n` rises is handled normally.
- Latency: 1 cycle from `din`/`parity_in` sampled to `dout`/`byte_err`/`word_err`.
- Statistics update on the same edge as `byte_err`.
- No back-pressure: a new word is accepted every cycle.
- Back-to-back valid words give back-to-back `dout_valid` pulses.
- Saturation: at `err_count = 2^CNT_W-1`, a further error leaves the count unchanged and `err_sticky=1`.

## Test plan
- Clean stream: 16 random words with correct even parity, e.g. `din=32'h0000_0001` with `parity_in=4'b0001`. Required: `dout` equals `din` one cycle later, `byte_err=0`, `err_count=0`, `err_irq=0`.
- Single byte error: `din=32'h0000_0001` with `parity_in=4'b0000`. Required next cycle: `byte_err=4'b0001`, `word_err=1`, `err_count=1`, `first_err_data=32'h0000_0001`, `first_err_byte=4'b0001`, `err_irq=1`.
- Multi-byte, then second error: `din=32'h0101_0101` with `parity_in=4'b0000` gives `byte_err=4'b1111` and `err_count=1`. A following bad word gives `err_count=2`, while `first_err_*` still holds the `32'h0101_0101` capture.
- Clear collision: with `err_count=5`, pulse `clr` together with a bad word `32'hFF00_0080`, `parity_in=4'b0000`. Required: `err_count=1`, `first_err_data=32'hFF00_0080`, `first_err_byte=4'b0001`. Note that byte 3 (`FF`) has even parity 0, so only byte 0 mismatches.
- Saturation and idle: with `CNT_W=2`, drive 5 bad words and require `err_count=3`. Gaps with `din_valid=0` give `dout_valid=0` and `byte_err=0`, with `dout` held.
- Reset mid-operation and ODD: assert `rst_n=0` for one cycle during a bad-word stream; every output is 0 afterwards. With `ODD=1`, `din=0` and `parity_in=4'b1111` gives no error.
